fle_frac_lutk: RTL and testbench
================================

// Module: fle_frac_lutk
// PURPOSE
//  Parametrised fracturable logic element with a built-in configuration bank.
//  One K-input LUT, or two (K-1)-input LUTs on shared inputs, drives two outputs.
//  Each output selects a combinational path or a clock-enabled FF path.
//  Config bits load and read back one bit per cycle over an address/data bus.
//  Instantiated inside CLB logical tiles, replacing the fixed single-output LUT4 BLE.
// PARAMETERS
//  K       4   LUT inputs; legal range 3..6
//  ADDR_W  5   config address width; 2**ADDR_W >= CFG_BITS (fatal elaboration check)
//  (local) CFG_BITS = 2**K + 3
// PORTS
//  clk        in   1       single clock: FFs, config writes, readback
//  reset      in   1       asynchronous, active-high; clears all state
//  fle_in     in   K       LUT inputs; fle_in[0] is index LSB
//  fle_ce     in   1       FF clock enable
//  enable     in   1       config write strobe
//  address    in   ADDR_W  config bit address (write and readback)
//  data_in    in   1       config write data
//  cfg_rdata  out  1       registered readback of cfg[address]
//  fle_out    out  2       element outputs
// BEHAVIOUR
//  Config map: cfg[0 .. 2**K-1] = truth table tt; cfg[2**K] = frac;
//   cfg[2**K+1] = reg_sel0; cfg[2**K+2] = reg_sel1.
//  Reset (async assert): cfg all 0, ff_q = 2'b00, cfg_rdata = 0.
//   At reset, fle_out = 2'b00 (tt all zero, comb path).
//   Reset deassertion is used synchronously; no write is accepted on the release edge.
//  Write: at posedge clk, if enable=1 and address < CFG_BITS, then cfg[address] <= data_in.
//   If address >= CFG_BITS, the write is ignored with no side effect.
//  Readback: at every posedge, cfg_rdata <= (address < CFG_BITS) ? cfg[address] : 0.
//   Readback latency is 1 cycle. If a write hits the same address in the same cycle,
//   cfg_rdata returns the old value; the new value appears on the following cycle.
//  LUT, combinational, with idx = fle_in as an unsigned K-bit value:
//   frac=0: lut0 = tt[idx]; lut1 = lut0.
//   frac=1: lut0 = tt[idx[K-2:0]]; lut1 = tt[2**(K-1) + idx[K-2:0]].
//    fle_in[K-1] is ignored in this mode.
//  FF: at posedge, if fle_ce=1 then ff_q[i] <= lut_i; otherwise ff_q holds.
//   A FF capture and a config write on the same edge: the FF captures lut_i computed
//   from pre-edge cfg. The new cfg affects the comb path only after the edge.
//  Output: fle_out[i] = reg_sel_i ? ff_q[i] : lut_i (combinational mux, no added latency).
//  Comb-path latency is 0 cycles. Registered-path latency is 1 edge with fle_ce=1.
//  Reset mid-config: bits already written are lost; software must reload the full bank.
//  Reset mid-operation: fle_out is forced to 00 immediately, independent of clk.
//  No X propagation: every cfg bit has a reset value. Coverage of unused addresses is required.
// TESTING
//  1. K=4. Write tt=16'h8000 (AND4), frac=0, reg_sel=00. Drive fle_in=4'hF -> fle_out=2'b11.
//     Drive fle_in=4'hE -> fle_out=2'b00.
//  2. Frac mode. Write tt[7:0]=8'h96 (XOR3), tt[15:8]=8'hE8 (MAJ3), frac=1.
//     fle_in=4'b1011 -> fle_out[0]=0, fle_out[1]=1. Toggling fle_in[3] has no effect.
//  3. Registered path. reg_sel0=1, AND4 loaded, fle_in=4'hF, fle_ce=0 for 3 cycles
//     -> fle_out[0] stays 0. Then fle_ce=1 for one edge -> fle_out[0]=1 after that edge;
//     fle_out[1]=1 (comb) throughout.
//  4. Bounds and readback. Write address=5'd31 with data 1 -> no cfg change.
//     Readback of addr 31 returns 0. Readback of addr 16 returns the value written
//     one cycle after the address is presented.
//  5. Same-edge hazard. fle_ce=1 and a write tt[15]=0 on the same edge with fle_in=4'hF
//     -> ff_q[0]=1 (old tt); the comb output drops to 0 after that edge.
//  6. Reset mid-operation. With outputs at 11, assert reset between clock edges
//     -> fle_out=00 and cfg_rdata=0 at once. After release, all addresses read back 0.

Source files
------------

// File: rtl/fle_frac_lutk_if.sv
// Bus bundle for the fracturable logic element: LUT inputs, FF enable,
// configuration write/readback port and the two element outputs.
interface fle_frac_lutk_if #(
  parameter int K      = 4,
  parameter int ADDR_W = 5
);
  logic [K-1:0]      fle_in;
  logic              fle_ce;
  logic              enable;
  logic [ADDR_W-1:0] address;
  logic              data_in;
  logic              cfg_rdata;
  logic [1:0]        fle_out;

  modport master (
    output fle_in, fle_ce, enable, address, data_in,
    input  cfg_rdata, fle_out
  );

  modport slave (
    input  fle_in, fle_ce, enable, address, data_in,
    output cfg_rdata, fle_out
  );
endinterface

// File: rtl/fle_frac_lutk.sv
// Fracturable K-input logic element: one K-LUT or two (K-1)-LUTs on shared inputs,
// each output muxed between comb and clock-enabled FF path, with a bit-serial config bank.
module fle_frac_lutk #(
  parameter int K      = 4,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  fle_frac_lutk_if.slave  bus
);
  localparam int TT_BITS  = 2**K;
  localparam int HALF     = 2**(K-1);
  localparam int CFG_BITS = TT_BITS + 3;
  localparam int DEPTH    = 2**ADDR_W;

  generate
    if (K < 3 || K > 6) begin : g_bad_k
      $fatal(1, "fle_frac_lutk: K must be in 3..6");
    end
    if (DEPTH < CFG_BITS) begin : g_bad_addr
      $fatal(1, "fle_frac_lutk: ADDR_W too small for the config bank");
    end
  endgenerate

  logic [CFG_BITS-1:0] cfg_reg;
  logic [CFG_BITS-1:0] wr_en;
  logic [DEPTH-1:0]    cfg_pad;
  logic [1:0]          ff_q_reg;
  logic                rdata_reg;

  logic [TT_BITS-1:0]  tt;
  logic [HALF-1:0]     tt_lo;
  logic [HALF-1:0]     tt_hi;
  logic [K-2:0]        idx_lo;
  logic                frac;
  logic [1:0]          reg_sel;
  logic [1:0]          lut;

  // One-hot write decode; out-of-range addresses match no bit, so they are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < CFG_BITS; gi++) begin : g_wr_dec
      assign wr_en[gi] = bus.enable && (bus.address == ADDR_W'(gi));
    end
    // Zero-padded view of the bank so readback of unused addresses yields 0.
    for (gi = 0; gi < DEPTH; gi++) begin : g_pad
      if (gi < CFG_BITS) begin : g_used
        assign cfg_pad[gi] = cfg_reg[gi];
      end else begin : g_unused
        assign cfg_pad[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_reg   <= '0;
      rdata_reg <= 1'b0;
    end else begin
      cfg_reg   <= (cfg_reg & ~wr_en) | (wr_en & {CFG_BITS{bus.data_in}});
      rdata_reg <= cfg_pad[bus.address];
    end
  end

  assign tt      = cfg_reg[TT_BITS-1:0];
  assign tt_lo   = tt[HALF-1:0];
  assign tt_hi   = tt[TT_BITS-1:HALF];
  assign frac    = cfg_reg[TT_BITS];
  assign reg_sel = cfg_reg[TT_BITS+2:TT_BITS+1];
  assign idx_lo  = bus.fle_in[K-2:0];

  // In frac mode the top input is ignored and each half of tt forms its own LUT.
  always_comb begin
    lut = '0;
    if (frac) begin
      lut[0] = tt_lo[idx_lo];
      lut[1] = tt_hi[idx_lo];
    end else begin
      lut[0] = tt[bus.fle_in];
      lut[1] = tt[bus.fle_in];
    end
  end

  // FFs sample the LUT from pre-edge config, so a same-edge write is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_q_reg <= 2'b00;
    end else if (bus.fle_ce) begin
      ff_q_reg <= lut;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      assign bus.fle_out[gi] = reg_sel[gi] ? ff_q_reg[gi] : lut[gi];
    end
  endgenerate

  assign bus.cfg_rdata = rdata_reg;
endmodule

// File: tb/tb_fle_frac_lutk.sv
// Randomized and directed bench for fle_frac_lutk against a truth-table reference model.
module tb_fle_frac_lutk;
  localparam int K        = 4;
  localparam int ADDR_W   = 5;
  localparam int TT_BITS  = 2**K;
  localparam int HALF     = 2**(K-1);
  localparam int CFG_BITS = TT_BITS + 3;
  localparam int DEPTH    = 2**ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fle_frac_lutk_if #(.K(K), .ADDR_W(ADDR_W)) bus ();

  fle_frac_lutk #(.K(K), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: configuration bits, FF contents, last readback value.
  bit       m_cfg [CFG_BITS];
  bit [1:0] m_ff;
  bit       m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_lut(input int i, input int in);
    int lo;
    if (m_cfg[TT_BITS]) begin
      lo = in % HALF;
      return m_cfg[i * HALF + lo];
    end
    return m_cfg[in];
  endfunction

  function automatic logic [31:0] m_out(input int in);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      r[i] = m_cfg[TT_BITS + 1 + i] ? m_ff[i] : m_lut(i, in);
    return r;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < CFG_BITS; i++) m_cfg[i] = 1'b0;
    m_ff    = 2'b00;
    m_rdata = 1'b0;
  endfunction

  // One transaction: drive after the falling edge, check comb output, step one
  // rising edge through the model, then check readback and output again.
  task automatic cycle(input int in, input int ce, input int en, input int addr, input int din);
    bit [1:0] nf;
    @(negedge clk);
    bus.fle_in  = in[K-1:0];
    bus.fle_ce  = ce[0];
    bus.enable  = en[0];
    bus.address = addr[ADDR_W-1:0];
    bus.data_in = din[0];
    #1;
    check("comb_pre", {30'd0, bus.fle_out}, m_out(in));
    @(posedge clk);
    nf = m_ff;
    if (ce != 0) nf = {m_lut(1, in), m_lut(0, in)};
    m_rdata = (addr < CFG_BITS) ? m_cfg[addr] : 1'b0;
    if (en != 0 && addr < CFG_BITS) m_cfg[addr] = din[0];
    m_ff = nf;
    #1;
    check("rdata", {31'd0, bus.cfg_rdata}, {31'd0, m_rdata});
    check("out_post", {30'd0, bus.fle_out}, m_out(in));
    $display("txn in=%h ce=%0d en=%0d addr=%0d din=%0d -> out=%b rdata=%0d",
             in[K-1:0], ce, en, addr, din, bus.fle_out, bus.cfg_rdata);
  endtask

  task automatic load_tt(input logic [TT_BITS-1:0] tt, input int in);
    for (int a = 0; a < TT_BITS; a++) cycle(in, 0, 1, a, int'(tt[a]));
  endtask

  initial begin
    logic [TT_BITS-1:0] tt;
    bus.fle_in  = '0;
    bus.fle_ce  = 1'b0;
    bus.enable  = 1'b0;
    bus.address = '0;
    bus.data_in = 1'b0;
    m_clear();

    // Reset state
    #3 reset = 1'b1;
    #1;
    check("rst_out", {30'd0, bus.fle_out}, 32'd0);
    check("rst_rdata", {31'd0, bus.cfg_rdata}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // AND4, comb path
    load_tt(16'h8000, 0);
    for (int a = TT_BITS; a < CFG_BITS; a++) cycle(0, 0, 1, a, 0);
    cycle(4'hF, 0, 0, 0, 0);
    check("t1_and4_F", {30'd0, bus.fle_out}, 32'd3);
    cycle(4'hE, 0, 0, 0, 0);
    check("t1_and4_E", {30'd0, bus.fle_out}, 32'd0);

    // Frac mode: XOR3 low half, MAJ3 high half
    tt = 16'hE896;
    load_tt(tt, 0);
    cycle(0, 0, 1, TT_BITS, 1);
    cycle(4'b1011, 0, 0, TT_BITS, 0);
    check("t2_frac_1011", {30'd0, bus.fle_out}, 32'd2);
    check("t4_rd16", {31'd0, bus.cfg_rdata}, 32'd1);
    cycle(4'b0011, 0, 0, 0, 0);
    check("t2_frac_0011", {30'd0, bus.fle_out}, 32'd2);

    // Out-of-range write is dropped; readback of unused address is 0
    cycle(4'b0011, 0, 1, 31, 1);
    cycle(4'b0011, 0, 0, 31, 0);
    check("t4_rd31", {31'd0, bus.cfg_rdata}, 32'd0);

    // Registered path on output 0
    load_tt(16'h8000, 0);
    cycle(0, 0, 1, TT_BITS, 0);
    cycle(0, 0, 1, TT_BITS + 1, 1);
    for (int c = 0; c < 3; c++) begin
      cycle(4'hF, 0, 0, 0, 0);
      check("t3_hold", {30'd0, bus.fle_out}, 32'd2);
    end
    cycle(4'hF, 1, 0, 0, 0);
    check("t3_capture", {30'd0, bus.fle_out}, 32'd3);

    // Same-edge FF capture and tt[15] write
    cycle(0, 1, 0, 0, 0);
    check("t5_cleared", {30'd0, bus.fle_out}, 32'd0);
    cycle(4'hF, 1, 1, 15, 0);
    check("t5_hazard", {30'd0, bus.fle_out}, 32'd1);

    // Asynchronous reset with outputs high
    cycle(4'hF, 0, 1, 15, 1);
    cycle(4'hF, 1, 0, TT_BITS + 1, 0);
    check("t6_pre", {30'd0, bus.fle_out}, 32'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_out", {30'd0, bus.fle_out}, 32'd0);
    check("t6_rst_rdata", {31'd0, bus.cfg_rdata}, 32'd0);
    m_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) cycle(4'hF, 0, 0, a, 0);

    // Randomized traffic over the whole address space
    for (int n = 0; n < 400; n++) begin
      cycle(int'($urandom_range(0, TT_BITS - 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
